// File: rtl/shift_loader.sv
// shift_loader: serial-to-parallel front end that frames WIDTH qualified bits after a start pulse
// and presents the assembled word with a one-cycle load strobe; restart mid-frame aborts the frame.
module shift_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             load,
    output logic             busy,
    output logic             abort
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_q, load_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic [WIDTH-1:0] shifted;
    logic             last;

    always_comb begin
        shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        load_d  = 1'b0;
        abort_d = 1'b0;
        // start wins over everything, including a pending final bit
        if (start) begin
            abort_d = state_q == SHIFT;
            state_d = SHIFT;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (state_q == SHIFT && sin_valid) begin
            shreg_d = shifted;
            cnt_d   = last ? '0 : cnt_q + CW'(1);
            data_d  = last ? shifted : data_q;
            load_d  = last;
            state_d = last ? IDLE : SHIFT;
        end
        busy_d = state_d == SHIFT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    assign data_out = data_q;
    assign load     = load_q;
    assign busy     = busy_q;
    assign abort    = abort_q;
endmodule

// File: tb/tb_shift_loader.sv
// tb_shift_loader: drives an MSB-first and an LSB-first instance with the same serial stream and
// compares both against a bit-list reference model, plus directed constant checks.
module tb_shift_loader;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, start, sin, sin_valid;
    logic [W-1:0] d1, d0;
    logic l1, l0, b1, b0, a1, a0;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int last_load = -1;
    int t0;
    logic [W-1:0] saved;

    // reference model: a frame is just the list of bits accepted since start
    bit           m_busy;
    bit           m_bits[$];
    logic [W-1:0] m_d1, m_d0;
    bit           m_load, m_abort;

    always #5 clk = ~clk;

    shift_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
        .data_out(d1), .load(l1), .busy(b1), .abort(a1)
    );

    shift_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
        .data_out(d0), .load(l0), .busy(b0), .abort(a0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_busy = 0; m_bits.delete(); m_d1 = '0; m_d0 = '0; m_load = 0; m_abort = 0;
    endtask

    task automatic m_step(input bit s, input bit b, input bit v);
        m_load = 0; m_abort = 0;
        if (s) begin
            m_abort = m_busy;
            m_busy = 1;
            m_bits.delete();
        end else if (m_busy && v) begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                m_d1 = '0; m_d0 = '0;
                for (int i = 0; i < W; i++) begin
                    if (m_bits[i]) begin
                        m_d1 = m_d1 + (W'(1) << (W - 1 - i));
                        m_d0 = m_d0 + (W'(1) << i);
                    end
                end
                m_load = 1; m_busy = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("data_msb", 32'(d1), 32'(m_d1));
        chk("data_lsb", 32'(d0), 32'(m_d0));
        chk("load_msb", 32'(l1), 32'(m_load));
        chk("load_lsb", 32'(l0), 32'(m_load));
        chk("busy_msb", 32'(b1), 32'(m_busy));
        chk("busy_lsb", 32'(b0), 32'(m_busy));
        chk("abort_msb", 32'(a1), 32'(m_abort));
        chk("abort_lsb", 32'(a0), 32'(m_abort));
    endtask

    task automatic cyc(input bit s, input bit b, input bit v);
        start = s; sin = b; sin_valid = v;
        @(posedge clk);
        m_step(s, b, v);
        #1;
        cyc_n++;
        if (l1 === 1'b1) last_load = cyc_n;
        check_all();
    endtask

    task automatic bits8(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) cyc(0, v[i], 1);
    endtask

    task automatic async_reset();
        rst = 1'b0;
        #1;
        m_reset();
        check_all();
        chk("rst_busy", 32'(b1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; start = 0; sin = 0; sin_valid = 0;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            sin = ~sin; sin_valid = 1;
            @(posedge clk);
            #1;
            chk("rst_data", 32'(d1), 32'h0);
            chk("rst_load", 32'(l1), 32'h0);
            chk("rst_busy", 32'(b1), 32'h0);
            chk("rst_abort", 32'(a1), 32'h0);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, i[0], 1);

        // A5 frame, both bit orders
        cyc(1, 0, 0); t0 = cyc_n;
        bits8(8'hA5);
        chk("a5_msb", 32'(d1), 32'hA5);
        chk("a5_lsb", 32'(d0), 32'hA5);
        chk("a5_latency", 32'(last_load - t0), 32'd8);
        // back-to-back: start while load is high, then bits 1,1,0,0,0,0,0,0
        cyc(1, 0, 0);
        chk("b2b_hold", 32'(d1), 32'hA5);
        bits8(8'hC0);
        chk("c0_msb", 32'(d1), 32'hC0);
        chk("c0_lsb", 32'(d0), 32'h03);
        cyc(0, 0, 0);
        chk("load_one_cycle", 32'(l1), 32'd0);
        chk("busy_fall", 32'(b1), 32'd0);

        // 3C with a 3-cycle stall between bits 4 and 5
        cyc(1, 0, 0); t0 = cyc_n;
        cyc(0, 0, 1); cyc(0, 0, 1); cyc(0, 1, 1); cyc(0, 1, 1);
        cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 1, 0);
        cyc(0, 1, 1); cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 0, 1);
        chk("stall_data", 32'(d1), 32'h3C);
        chk("stall_latency", 32'(last_load - t0), 32'd11);

        // abort after 5 bits, then a clean 81
        cyc(1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1);
        saved = d1;
        cyc(1, 1, 1);
        chk("abort_pulse", 32'(a1), 32'd1);
        chk("abort_keep", 32'(d1), 32'(saved));
        bits8(8'h81);
        chk("after_abort", 32'(d1), 32'h81);
        // start coincident with the 8th bit
        cyc(1, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1);
        cyc(1, 1, 1);
        chk("abort_last_pulse", 32'(a1), 32'd1);
        chk("abort_last_noload", 32'(l1), 32'd0);
        chk("abort_last_keep", 32'(d1), 32'h81);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1);
        cyc(0, 0, 0);

        // mid-frame reset after 3 bits, then FF
        cyc(1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1);
        async_reset();
        chk("midrst_data", 32'(d1), 32'h0);
        cyc(0, 0, 0);
        chk("midrst_noload", 32'(l1), 32'd0);
        cyc(1, 0, 0);
        bits8(8'hFF);
        chk("ff_frame", 32'(d1), 32'hFF);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            else cyc($urandom_range(0, 15) == 0, 1'($urandom), $urandom_range(0, 3) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
